// File: rtl/sm83_adr_seq_if.sv
// Command and strobe bundle between the two requesters, the sequencer and the
// SM83 address latch/incrementer unit.
interface sm83_adr_seq_if;
  logic       cpu_valid;
  logic       cpu_ready;
  logic [2:0] cpu_op;
  logic [1:0] cpu_cnt;
  logic       irq_valid;
  logic       irq_ready;
  logic [2:0] irq_op;
  logic [1:0] irq_cnt;
  logic       ctl_al_we;
  logic       ctl_al_hi_ff;
  logic       ctl_inc_dec;
  logic       ctl_inc_cy;
  logic       ctl_inc_oe;
  logic       busy;
  logic       grant;
  logic       done;

  modport master (
    output cpu_valid, cpu_op, cpu_cnt, irq_valid, irq_op, irq_cnt,
    input  cpu_ready, irq_ready, ctl_al_we, ctl_al_hi_ff, ctl_inc_dec,
           ctl_inc_cy, ctl_inc_oe, busy, grant, done
  );

  modport slave (
    input  cpu_valid, cpu_op, cpu_cnt, irq_valid, irq_op, irq_cnt,
    output cpu_ready, irq_ready, ctl_al_we, ctl_al_hi_ff, ctl_inc_dec,
           ctl_inc_cy, ctl_inc_oe, busy, grant, done
  );
endinterface

// File: rtl/sm83_adr_seq.sv
// Arbitrates cpu/irq address-unit commands and expands each into 1..4 registered
// strobe steps, with starvation protection for the irq requester.
module sm83_adr_seq #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic           clk,
  input  logic           reset,
  sm83_adr_seq_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic we;
    logic hi_ff;
    logic dec;
    logic cy;
    logic oe;
  } strobe_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  function automatic strobe_t decode(input logic [2:0] op);
    strobe_t s;
    case (op)
      3'd1:    s = 5'b10000; // LD
      3'd2:    s = 5'b11000; // LDH
      3'd3:    s = 5'b10011; // INC
      3'd4:    s = 5'b10111; // DEC
      3'd5:    s = 5'b10001; // RFSH
      default: s = 5'b00000; // NOP and reserved opcodes
    endcase
    return s;
  endfunction

  state_t     state, state_d;
  logic [1:0] remaining, remaining_d;
  logic [3:0] starve, starve_d;
  strobe_t    strobe, strobe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       grant_q, grant_d;

  logic accept_pt, starved, cpu_ready, irq_ready, cpu_fire, irq_fire;

  // Ready depends only on our state and the peer's valid, never on its own valid.
  assign accept_pt = (state == IDLE) || (remaining == 2'd0);
  assign starved   = (starve == STARVE_LIM);
  assign cpu_ready = !reset && accept_pt && !(bus.irq_valid && starved);
  assign irq_ready = !reset && accept_pt && !(bus.cpu_valid && !starved);
  assign cpu_fire  = bus.cpu_valid && cpu_ready;
  assign irq_fire  = bus.irq_valid && irq_ready;

  // State register (also registers every output so they are stable at negedge).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of statement order.
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      starve    <= '0;
      strobe    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      grant_q   <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      starve    <= starve_d;
      strobe    <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      grant_q   <= grant_d;
    end
  end

  // Next-state logic: load on accept, count down, else fall back to IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d     = IDLE;
    remaining_d = '0;
    starve_d    = starve;
    if (cpu_fire || irq_fire) begin
      state_d     = RUN;
      remaining_d = irq_fire ? bus.irq_cnt : bus.cpu_cnt;
    end else if (state == RUN && remaining != 2'd0) begin
      state_d     = RUN;
      remaining_d = remaining - 2'd1;
    end
    if (accept_pt) begin
      if (irq_fire || !bus.irq_valid)
        starve_d = '0;
      else if (cpu_fire && !starved)
        starve_d = starve + 4'd1;
    end
  end

  // Output logic: strobe pattern is fixed per command, captured at accept.
  always_comb begin
    strobe_d = '0;
    grant_d  = grant_q;
    if (cpu_fire || irq_fire) begin
      strobe_d = decode(irq_fire ? bus.irq_op : bus.cpu_op);
      grant_d  = irq_fire;
    end else if (state_d == RUN) begin
      strobe_d = strobe;
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == RUN) && (remaining_d == 2'd0);
  end

  assign bus.cpu_ready    = cpu_ready;
  assign bus.irq_ready    = irq_ready;
  assign bus.ctl_al_we    = strobe.we;
  assign bus.ctl_al_hi_ff = strobe.hi_ff;
  assign bus.ctl_inc_dec  = strobe.dec;
  assign bus.ctl_inc_cy   = strobe.cy;
  assign bus.ctl_inc_oe   = strobe.oe;
  assign bus.busy         = busy_q;
  assign bus.grant        = grant_q;
  assign bus.done         = done_q;

endmodule
